branch_predict_unit: RTL and testbench
======================================

# branch_predict_unit

Parametrised branch unit with dynamic prediction for the single-issue RISC-V core. It holds a direct-mapped table of 2-bit saturating counters plus a tagged branch target buffer (BTB). The fetch stage reads a prediction; the execute stage resolves branches against the carried prediction and drives a redirect on mispredict. The unit also keeps resolved-branch and mispredict statistics.

## Interface
Parameters:
- PC_WIDTH, 9, width of the byte-address program counter.
- BHT_DEPTH, 16, entries in the counter table and BTB; power of two, 2..256; IDX_W = log2(BHT_DEPTH); requires PC_WIDTH >= IDX_W+3.
- STAT_WIDTH, 16, width of the statistics counters.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- FetchPC  in  PC_WIDTH  PC being fetched this cycle.
- PredTaken  out  1  fetch prediction: redirect fetch to PredTarget.
- PredTarget  out  32  predicted target; 0 when PredTaken=0.
- ExValid  in  1  valid instruction in execute.
- ExBranch  in  1  that instruction is a conditional branch.
- ExPC  in  PC_WIDTH  PC of the execute instruction.
- ExImm  in  32  sign-extended branch offset.
- ExALUResult  in  32  compare result; bit 0 = condition true.
- ExPredTaken  in  1  PredTaken carried down the pipe with the instruction.
- ExPredTarget  in  32  PredTarget carried with the instruction.
- Redirect  out  1  mispredict: flush younger instructions and load RedirectPC.
- RedirectPC  out  32  correct next PC; 0 when Redirect=0.
- BranchCount  out  STAT_WIDTH  resolved conditional branches.
- MispredCount  out  STAT_WIDTH  redirects issued.

## Operation
- Index = PC[IDX_W+1:2]. Tag = PC[PC_WIDTH-1:IDX_W+2]. PCs are zero-extended to 32 bits.
- Each entry holds a 2-bit counter (CTR), a BTB valid bit, a tag, and a 32-bit target.
- Prediction is combinational from registered state: PredTaken = CTR[1] && valid && tag match at FetchPC's index. PredTarget = entry target when PredTaken=1, else 0.
- Resolve when ExValid=1 and reset=0:
  - PCFour = ExPC + 4 and PCImm = ExPC + ExImm, both modulo 2^32.
  - Actual = ExBranch && ExALUResult[0].
  - Actual target = PCImm if Actual=1, else PCFour.
  - Mispredict when Actual != ExPredTaken, or when both are 1 and ExPredTarget != PCImm.
  - On mispredict: Redirect=1 and RedirectPC = actual target.
- Table update at the edge, only when ExValid && ExBranch:
  - CTR increments if Actual=1, saturating at 11; decrements if Actual=0, saturating at 00.
  - If Actual=1, BTB entry is written: valid=1, tag from ExPC, target = PCImm.
  - If Actual=0, the BTB entry is left unchanged.
- Non-branch with ExPredTaken=1 (aliasing): counts as a mispredict and redirects to PCFour. The BTB valid bit at ExPC's index is cleared; CTR is unchanged.
- Statistics at the edge:
  - BranchCount increments on ExValid && ExBranch.
  - MispredCount increments on Redirect.
  - Both wrap modulo 2^STAT_WIDTH.
- ExValid=0: no redirect, no table or statistics change; all other Ex inputs are ignored.

## Timing
- Reset (synchronous, 1 edge):
  - All CTR = 01 (weakly not-taken); all BTB valid = 0, tags and targets = 0.
  - BranchCount = MispredCount = 0.
  - PredTaken=0, PredTarget=0 from the cycle after the reset edge.
- While reset=1, Redirect=0 and RedirectPC=0 regardless of inputs, and no updates occur.
- Reset mid-resolve: the update is discarded; the table is cleared at the edge.
- Prediction latency 0 cycles: PredTaken/PredTarget follow FetchPC combinationally.
- Redirect latency 0 cycles: Redirect/RedirectPC are valid in the same cycle as the execute inputs.
- Table write latency: visible to fetch from the cycle after the resolving edge.
- Same-cycle fetch/resolve on one index: fetch sees the pre-update value; there is no bypass.
- Consecutive resolves to the same entry update back-to-back; each edge sees the previous edge's result.
- One resolve per cycle maximum; a second resolve port is not supported.

## Test plan
- Reset, then FetchPC=0x040 -> PredTaken=0, PredTarget=0, both counters 0. Hold reset with ExValid=1, ExBranch=1, ExALUResult=1 -> Redirect=0, no update.
- Branch at ExPC=0x040, ExImm=0xFFFFFFF0, taken, ExPredTaken=0:
  - First resolve -> Redirect=1, RedirectPC=0x030, MispredCount=1.
  - Next cycle, FetchPC=0x040 -> PredTaken=1, PredTarget=0x030 (CTR=10).
- Same branch resolved taken 3 more times (saturates at 11), then not-taken with ExPredTaken=1 -> Redirect=1, RedirectPC=0x044. Next fetch still predicts taken (CTR=10). A second not-taken -> CTR=01, fetch predicts not-taken.
- Alias: ExPC=0x080 is the same index as 0x040 with a different tag; FetchPC=0x080 -> PredTaken=0. Non-branch at 0x040 with ExPredTaken=1 -> Redirect=1, RedirectPC=0x044; BTB entry invalidated.
- Target mismatch: ExPredTaken=1, ExPredTarget=0x030, actual taken with PCImm=0x050 -> Redirect=1, RedirectPC=0x050; BTB target becomes 0x050.
- Counter wrap: with STAT_WIDTH=4, resolve 17 branches -> BranchCount=1. Wrap arithmetic: ExPC=0x1FC, ExImm=0xFFFFFE04 -> PCImm=0x00000000.

Source files
------------

// File: rtl/branch_predict_unit.sv
// Dynamic branch predictor: direct-mapped 2-bit counter table plus tagged BTB,
// with execute-stage resolution, mispredict redirect and resolve statistics.
module branch_predict_unit #(
  parameter int PC_WIDTH   = 9,
  parameter int BHT_DEPTH  = 16,
  parameter int STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PC_WIDTH-1:0]   FetchPC,
  output logic                  PredTaken,
  output logic [31:0]           PredTarget,
  input  logic                  ExValid,
  input  logic                  ExBranch,
  input  logic [PC_WIDTH-1:0]   ExPC,
  input  logic [31:0]           ExImm,
  input  logic [31:0]           ExALUResult,
  input  logic                  ExPredTaken,
  input  logic [31:0]           ExPredTarget,
  output logic                  Redirect,
  output logic [31:0]           RedirectPC,
  output logic [STAT_WIDTH-1:0] BranchCount,
  output logic [STAT_WIDTH-1:0] MispredCount
);

  localparam int IDX_W = $clog2(BHT_DEPTH);
  localparam int TAG_W = PC_WIDTH - IDX_W - 2;

  logic [1:0]       r_ctr    [BHT_DEPTH];
  logic             r_valid  [BHT_DEPTH];
  logic [TAG_W-1:0] r_tag    [BHT_DEPTH];
  logic [31:0]      r_target [BHT_DEPTH];

  logic [STAT_WIDTH-1:0] r_branchCount;
  logic [STAT_WIDTH-1:0] r_mispredCount;

  logic [IDX_W-1:0] w_fetchIdx;
  logic [TAG_W-1:0] w_fetchTag;
  logic [IDX_W-1:0] w_exIdx;
  logic [TAG_W-1:0] w_exTag;
  logic [31:0]      w_exPC32;
  logic [31:0]      w_pcFour;
  logic [31:0]      w_pcImm;
  logic             w_actual;
  logic             w_mispredict;
  logic             w_resolve;
  logic [1:0]       w_ctrNext;

  assign w_fetchIdx = FetchPC[IDX_W+1:2];
  assign w_fetchTag = FetchPC[PC_WIDTH-1:IDX_W+2];
  assign w_exIdx    = ExPC[IDX_W+1:2];
  assign w_exTag    = ExPC[PC_WIDTH-1:IDX_W+2];

  // Prediction reads registered state only; a same-cycle resolve is not bypassed.
  assign PredTaken  = r_ctr[w_fetchIdx][1] && r_valid[w_fetchIdx] &&
                      (r_tag[w_fetchIdx] == w_fetchTag);
  assign PredTarget = PredTaken ? r_target[w_fetchIdx] : 32'd0;

  assign w_exPC32 = 32'(ExPC);
  assign w_pcFour = w_exPC32 + 32'd4;
  assign w_pcImm  = w_exPC32 + ExImm;
  assign w_actual = ExBranch && ExALUResult[0];

  assign w_resolve    = ExValid && !reset;
  assign w_mispredict = w_resolve &&
                        ((w_actual != ExPredTaken) ||
                         (w_actual && ExPredTaken && (ExPredTarget != w_pcImm)));

  assign Redirect   = w_mispredict;
  assign RedirectPC = w_mispredict ? (w_actual ? w_pcImm : w_pcFour) : 32'd0;

  always_comb begin
    w_ctrNext = r_ctr[w_exIdx];
    if (w_actual) begin
      if (w_ctrNext != 2'b11) w_ctrNext = w_ctrNext + 2'd1;
    end else begin
      if (w_ctrNext != 2'b00) w_ctrNext = w_ctrNext - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        r_ctr[i]    <= 2'b01;
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= 32'd0;
      end
    end else if (ExValid) begin
      if (ExBranch) begin
        r_ctr[w_exIdx] <= w_ctrNext;
        if (w_actual) begin
          r_valid[w_exIdx]  <= 1'b1;
          r_tag[w_exIdx]    <= w_exTag;
          r_target[w_exIdx] <= w_pcImm;
        end
      end else if (ExPredTaken) begin
        // A non-branch hit the BTB through aliasing; drop the stale entry.
        r_valid[w_exIdx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_branchCount  <= '0;
      r_mispredCount <= '0;
    end else begin
      if (ExValid && ExBranch) r_branchCount <= r_branchCount + 1'b1;
      if (w_mispredict)        r_mispredCount <= r_mispredCount + 1'b1;
    end
  end

  assign BranchCount  = r_branchCount;
  assign MispredCount = r_mispredCount;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed vector table, hand-written
// wrap sequence, then randomized traffic against a behavioural predictor model.
module tb_branch_predict_unit;

  localparam int PCW   = 9;
  localparam int DEPTH = 16;
  localparam int STATW = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [PCW-1:0]   FetchPC = '0;
  logic             PredTaken;
  logic [31:0]      PredTarget;
  logic             ExValid = 1'b0;
  logic             ExBranch = 1'b0;
  logic [PCW-1:0]   ExPC = '0;
  logic [31:0]      ExImm = '0;
  logic [31:0]      ExALUResult = '0;
  logic             ExPredTaken = 1'b0;
  logic [31:0]      ExPredTarget = '0;
  logic             Redirect;
  logic [31:0]      RedirectPC;
  logic [STATW-1:0] BranchCount;
  logic [STATW-1:0] MispredCount;

  int checks = 0;
  int errors = 0;

  branch_predict_unit #(.PC_WIDTH(PCW), .BHT_DEPTH(DEPTH), .STAT_WIDTH(STATW)) dut (
    .clk(clk), .reset(reset), .FetchPC(FetchPC),
    .PredTaken(PredTaken), .PredTarget(PredTarget),
    .ExValid(ExValid), .ExBranch(ExBranch), .ExPC(ExPC), .ExImm(ExImm),
    .ExALUResult(ExALUResult), .ExPredTaken(ExPredTaken), .ExPredTarget(ExPredTarget),
    .Redirect(Redirect), .RedirectPC(RedirectPC),
    .BranchCount(BranchCount), .MispredCount(MispredCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    int          fetchPC;
    bit          exValid;
    bit          exBranch;
    int          exPC;
    logic [31:0] exImm;
    bit          cond;
    bit          predT;
    logic [31:0] predTgt;
    bit          expPredTaken;
    logic [31:0] expPredTarget;
    bit          expRedirect;
    logic [31:0] expRedirectPC;
    int          expBranchCount;
    int          expMispredCount;
  } vec_t;

  // Behavioural model: one record per table slot, counters as plain integers 0..3.
  int          mCtr   [DEPTH];
  bit          mValid [DEPTH];
  int          mTag   [DEPTH];
  logic [31:0] mTgt   [DEPTH];
  int          mBranches;
  int          mMispreds;

  function automatic int idxOf(int pc);
    return (pc / 4) % DEPTH;
  endfunction

  function automatic int tagOf(int pc);
    return pc / (4 * DEPTH);
  endfunction

  function automatic bit modelPredicts(int pc);
    int i = idxOf(pc);
    return (mCtr[i] >= 2) && mValid[i] && (mTag[i] == tagOf(pc));
  endfunction

  task automatic modelReset();
    for (int i = 0; i < DEPTH; i++) begin
      mCtr[i] = 1; mValid[i] = 1'b0; mTag[i] = 0; mTgt[i] = 32'd0;
    end
    mBranches = 0;
    mMispreds = 0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives one cycle; compares combinational outputs before the edge and counters after it.
  task automatic applyStimulus(input vec_t v, input bit useTable);
    logic [31:0] pcImm, pcFour, mPT, mRd, mRdPC;
    bit actual, mis;
    int i;
    @(negedge clk);
    reset        = v.rst;
    FetchPC      = PCW'(v.fetchPC);
    ExValid      = v.exValid;
    ExBranch     = v.exBranch;
    ExPC         = PCW'(v.exPC);
    ExImm        = v.exImm;
    ExALUResult  = {31'($urandom), v.cond};
    ExPredTaken  = v.predT;
    ExPredTarget = v.predTgt;
    #1;
    pcImm  = 32'(v.exPC) + v.exImm;
    pcFour = 32'(v.exPC) + 32'd4;
    actual = v.exBranch && v.cond;
    mis    = v.exValid && !v.rst &&
             ((actual != v.predT) || (actual && v.predT && (v.predTgt != pcImm)));
    mPT    = {31'd0, modelPredicts(v.fetchPC)};
    mRd    = {31'd0, mis};
    mRdPC  = mis ? (actual ? pcImm : pcFour) : 32'd0;
    if (useTable) begin
      checkOutput("PredTaken", {31'd0, PredTaken}, {31'd0, v.expPredTaken});
      checkOutput("PredTarget", PredTarget, v.expPredTarget);
      checkOutput("Redirect", {31'd0, Redirect}, {31'd0, v.expRedirect});
      checkOutput("RedirectPC", RedirectPC, v.expRedirectPC);
    end else begin
      checkOutput("PredTaken", {31'd0, PredTaken}, mPT);
      checkOutput("PredTarget", PredTarget, mPT[0] ? mTgt[idxOf(v.fetchPC)] : 32'd0);
      checkOutput("Redirect", {31'd0, Redirect}, mRd);
      checkOutput("RedirectPC", RedirectPC, mRdPC);
    end
    @(posedge clk);
    if (v.rst) begin
      modelReset();
    end else if (v.exValid) begin
      i = idxOf(v.exPC);
      if (v.exBranch) begin
        mCtr[i] = actual ? ((mCtr[i] == 3) ? 3 : mCtr[i] + 1)
                         : ((mCtr[i] == 0) ? 0 : mCtr[i] - 1);
        if (actual) begin
          mValid[i] = 1'b1; mTag[i] = tagOf(v.exPC); mTgt[i] = pcImm;
        end
        mBranches = (mBranches + 1) % (1 << STATW);
      end else if (v.predT) begin
        mValid[i] = 1'b0;
      end
      if (mis) mMispreds = (mMispreds + 1) % (1 << STATW);
    end
    #1;
    if (useTable) begin
      checkOutput("BranchCount", 32'(BranchCount), 32'(v.expBranchCount));
      checkOutput("MispredCount", 32'(MispredCount), 32'(v.expMispredCount));
    end else begin
      checkOutput("BranchCount", 32'(BranchCount), 32'(mBranches));
      checkOutput("MispredCount", 32'(MispredCount), 32'(mMispreds));
    end
  endtask

  task automatic pulseReset();
    @(negedge clk);
    reset   = 1'b1;
    ExValid = 1'b0;
    @(posedge clk);
    modelReset();
    #1;
  endtask

  vec_t vecs[$];
  vec_t v;

  initial begin
    // rst fetch  vld br  exPC   imm          c  pT tgt      | ePT eTgt    eRd ePC        BC MC
    vecs.push_back(vec_t'{1, 'h040, 1, 1, 'h040, 32'hFFFFFFF0, 1, 0, 32'h0,   0, 32'h0,   0, 32'h0,   0, 0});
    vecs.push_back(vec_t'{0, 'h040, 1, 1, 'h040, 32'hFFFFFFF0, 1, 0, 32'h0,   0, 32'h0,   1, 32'h030, 1, 1});
    vecs.push_back(vec_t'{0, 'h040, 0, 0, 'h000, 32'h0,        0, 0, 32'h0,   1, 32'h030, 0, 32'h0,   1, 1});
    vecs.push_back(vec_t'{0, 'h040, 1, 1, 'h040, 32'hFFFFFFF0, 1, 1, 32'h030, 1, 32'h030, 0, 32'h0,   2, 1});
    vecs.push_back(vec_t'{0, 'h040, 1, 1, 'h040, 32'hFFFFFFF0, 1, 1, 32'h030, 1, 32'h030, 0, 32'h0,   3, 1});
    vecs.push_back(vec_t'{0, 'h040, 1, 1, 'h040, 32'hFFFFFFF0, 1, 1, 32'h030, 1, 32'h030, 0, 32'h0,   4, 1});
    vecs.push_back(vec_t'{0, 'h040, 1, 1, 'h040, 32'hFFFFFFF0, 0, 1, 32'h030, 1, 32'h030, 1, 32'h044, 5, 2});
    vecs.push_back(vec_t'{0, 'h040, 0, 0, 'h000, 32'h0,        0, 0, 32'h0,   1, 32'h030, 0, 32'h0,   5, 2});
    vecs.push_back(vec_t'{0, 'h040, 1, 1, 'h040, 32'hFFFFFFF0, 0, 1, 32'h030, 1, 32'h030, 1, 32'h044, 6, 3});
    vecs.push_back(vec_t'{0, 'h040, 0, 0, 'h000, 32'h0,        0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   6, 3});
    vecs.push_back(vec_t'{0, 'h040, 1, 1, 'h040, 32'hFFFFFFF0, 1, 0, 32'h0,   0, 32'h0,   1, 32'h030, 7, 4});
    vecs.push_back(vec_t'{0, 'h080, 0, 0, 'h000, 32'h0,        0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   7, 4});
    vecs.push_back(vec_t'{0, 'h040, 0, 0, 'h000, 32'h0,        0, 0, 32'h0,   1, 32'h030, 0, 32'h0,   7, 4});
    vecs.push_back(vec_t'{0, 'h040, 1, 0, 'h040, 32'hFFFFFFF0, 1, 1, 32'h030, 1, 32'h030, 1, 32'h044, 7, 5});
    vecs.push_back(vec_t'{0, 'h040, 0, 0, 'h000, 32'h0,        0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   7, 5});
    vecs.push_back(vec_t'{0, 'h040, 1, 1, 'h040, 32'h00000010, 1, 1, 32'h030, 0, 32'h0,   1, 32'h050, 8, 6});
    vecs.push_back(vec_t'{0, 'h040, 0, 0, 'h000, 32'h0,        0, 0, 32'h0,   1, 32'h050, 0, 32'h0,   8, 6});
    vecs.push_back(vec_t'{0, 'h1FC, 1, 1, 'h1FC, 32'hFFFFFE04, 1, 1, 32'h0,   0, 32'h0,   0, 32'h0,   9, 6});
    vecs.push_back(vec_t'{0, 'h1FC, 0, 0, 'h000, 32'h0,        0, 0, 32'h0,   1, 32'h0,   0, 32'h0,   9, 6});

    pulseReset();
    for (int k = 0; k < vecs.size(); k++) applyStimulus(vecs[k], 1'b1);

    // Statistics wrap: 17 correctly predicted not-taken branches leave BranchCount at 1.
    pulseReset();
    for (int k = 0; k < 17; k++) begin
      v = vec_t'{0, 'h100, 1, 1, (k * 4) % 512, 32'h20, 0, 0, 32'h0,
                 0, 32'h0, 0, 32'h0, (k + 1) % 16, 0};
      applyStimulus(v, 1'b1);
    end

    // Randomized traffic against the model, with occasional mid-stream resets.
    pulseReset();
    for (int k = 0; k < 400; k++) begin
      v = '{default: 0};
      v.rst      = ($urandom_range(0, 49) == 0);
      v.fetchPC  = $urandom_range(0, 31) * 4 + 'h40 * $urandom_range(0, 3);
      v.exValid  = ($urandom_range(0, 3) != 0);
      v.exBranch = ($urandom_range(0, 4) != 0);
      v.exPC     = ($urandom_range(0, 15) * 4) + 'h40 * $urandom_range(0, 7);
      v.exImm    = $urandom_range(0, 1) ? 32'(-4 * $urandom_range(1, 40))
                                        : 32'(4 * $urandom_range(1, 40));
      v.cond     = $urandom_range(0, 1);
      v.predT    = ($urandom_range(0, 9) < 7) ? modelPredicts(v.exPC) : 1'($urandom);
      v.predTgt  = ($urandom_range(0, 4) != 0) ? mTgt[idxOf(v.exPC)] : $urandom;
      applyStimulus(v, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
